cpu_status_reg: RTL and testbench

//  Processor status register (P) for the 2A03 CPU core; the consumer end of
//  the ALU flag bus {N,V,Z,C}.
//  - Latches ALU flags under per-flag write enables, plus N/Z from loads.
//  - Executes flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED) and PLP.
//  - Packs P for PHP/BRK/IRQ pushes and evaluates branch conditions.
//  - Implements the one-instruction I-flag latency on IRQ polling.

---
 rtl/cpu_status_reg.sv | 146 ++++++++++++++
 tb/tb_cpu_status_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_status_reg.sv
// 2A03 processor status register: flag latching, P pack/unpack, branch test and IRQ poll latency.
// Define STATUS_DFLAG_EN to store the decimal (D) flag; otherwise D reads as 0.
module cpu_status_reg #(
    parameter logic RESET_I  = 1'b1,
    parameter logic BIT5_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [3:0] alu_flgs,
    input  logic [3:0] alu_we,
    input  logic       nz_we,
    input  logic [7:0] nz_data,
    input  logic [2:0] flg_op,
    input  logic       plp,
    input  logic [7:0] p_in,
    input  logic       push_b,
    output logic [7:0] p_out,
    input  logic       irq_set_i,
    input  logic       instr_end,
    input  logic       irq_line,
    output logic       irq_req,
    input  logic [1:0] br_sel,
    input  logic       br_val,
    output logic       br_taken
);

    localparam logic [2:0] OP_CLC = 3'b001;
    localparam logic [2:0] OP_SEC = 3'b010;
    localparam logic [2:0] OP_CLI = 3'b011;
    localparam logic [2:0] OP_SEI = 3'b100;
    localparam logic [2:0] OP_CLV = 3'b101;
`ifdef STATUS_DFLAG_EN
    localparam logic [2:0] OP_CLD = 3'b110;
    localparam logic [2:0] OP_SED = 3'b111;
`endif

    logic n_q, n_d;
    logic v_q, v_d;
    logic z_q, z_d;
    logic c_q, c_d;
    logic i_q, i_d;
    logic i_poll_q, i_poll_d;
    logic irq_req_q, irq_req_d;
    logic d_bit;

    // Each flag resolves its own priority chain: plp > irq_set_i > flg_op > alu_we > nz_we.
    always_comb begin
        n_d = n_q;
        if (plp)              n_d = p_in[7];
        else if (alu_we[3])   n_d = alu_flgs[3];
        else if (nz_we)       n_d = nz_data[7];

        v_d = v_q;
        if (plp)                   v_d = p_in[6];
        else if (flg_op == OP_CLV) v_d = 1'b0;
        else if (alu_we[2])        v_d = alu_flgs[2];

        z_d = z_q;
        if (plp)              z_d = p_in[1];
        else if (alu_we[1])   z_d = alu_flgs[1];
        else if (nz_we)       z_d = (nz_data == 8'h00);

        c_d = c_q;
        if (plp)                   c_d = p_in[0];
        else if (flg_op == OP_CLC) c_d = 1'b0;
        else if (flg_op == OP_SEC) c_d = 1'b1;
        else if (alu_we[0])        c_d = alu_flgs[0];

        i_d = i_q;
        if (plp)                   i_d = p_in[2];
        else if (irq_set_i)        i_d = 1'b1;
        else if (flg_op == OP_CLI) i_d = 1'b0;
        else if (flg_op == OP_SEI) i_d = 1'b1;
    end

    // The poll samples the mask as it stood before this instruction's own I update.
    always_comb begin
        i_poll_d  = i_poll_q;
        irq_req_d = irq_req_q;
        if (irq_set_i) begin
            i_poll_d  = 1'b1;
            irq_req_d = 1'b0;
        end else if (instr_end) begin
            i_poll_d  = i_d;
            irq_req_d = irq_line & ~i_poll_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            i_q       <= RESET_I;
            i_poll_q  <= RESET_I;
            irq_req_q <= 1'b0;
        end else if (en) begin
            n_q       <= n_d;
            v_q       <= v_d;
            z_q       <= z_d;
            c_q       <= c_d;
            i_q       <= i_d;
            i_poll_q  <= i_poll_d;
            irq_req_q <= irq_req_d;
        end
    end

`ifdef STATUS_DFLAG_EN
    logic d_q, d_d;
    logic unused_p_in;

    always_comb begin
        d_d = d_q;
        if (plp)                   d_d = p_in[3];
        else if (flg_op == OP_CLD) d_d = 1'b0;
        else if (flg_op == OP_SED) d_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)  d_q <= 1'b0;
        else if (en) d_q <= d_d;
    end

    assign d_bit       = d_q;
    assign unused_p_in = ^p_in[5:4];
`else
    logic unused_p_in;
    assign d_bit       = 1'b0;
    assign unused_p_in = ^p_in[5:3];
`endif

    assign p_out   = {n_q, v_q, BIT5_VAL, push_b, d_bit, i_q, z_q, c_q};
    assign irq_req = irq_req_q;

    always_comb begin
        case (br_sel)
            2'b00:   br_taken = (n_q == br_val);
            2'b01:   br_taken = (v_q == br_val);
            2'b10:   br_taken = (c_q == br_val);
            default: br_taken = (z_q == br_val);
        endcase
    end

endmodule

// File: tb/tb_cpu_status_reg.sv
// Self-checking bench for cpu_status_reg: directed cases plus randomized traffic against a flag-level model.
module tb_cpu_status_reg;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic [3:0] alu_flgs;
  logic [3:0] alu_we;
  logic       nz_we;
  logic [7:0] nz_data;
  logic [2:0] flg_op;
  logic       plp;
  logic [7:0] p_in;
  logic       push_b;
  logic [7:0] p_out;
  logic       irq_set_i;
  logic       instr_end;
  logic       irq_line;
  logic       irq_req;
  logic [1:0] br_sel;
  logic       br_val;
  logic       br_taken;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

`ifdef STATUS_DFLAG_EN
  localparam bit HAS_D = 1'b1;
`else
  localparam bit HAS_D = 1'b0;
`endif

  cpu_status_reg dut (
    .clk(clk), .n_rst(n_rst), .en(en),
    .alu_flgs(alu_flgs), .alu_we(alu_we),
    .nz_we(nz_we), .nz_data(nz_data),
    .flg_op(flg_op), .plp(plp), .p_in(p_in),
    .push_b(push_b), .p_out(p_out),
    .irq_set_i(irq_set_i), .instr_end(instr_end), .irq_line(irq_line),
    .irq_req(irq_req),
    .br_sel(br_sel), .br_val(br_val), .br_taken(br_taken)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: P kept as a byte in its architectural bit layout
  logic [7:0] m_p;
  logic       m_ipoll;
  logic       m_irq;

  always @(posedge clk or negedge n_rst) begin
    logic [7:0] p;
    if (!n_rst) begin
      m_p     = 8'h04;
      m_ipoll = 1'b1;
      m_irq   = 1'b0;
    end else if (en) begin
      p = m_p;
      // apply lowest priority first so higher priorities overwrite
      if (nz_we) begin
        p[7] = nz_data[7];
        p[1] = (nz_data == 8'h00);
      end
      if (alu_we[3]) p[7] = alu_flgs[3];
      if (alu_we[2]) p[6] = alu_flgs[2];
      if (alu_we[1]) p[1] = alu_flgs[1];
      if (alu_we[0]) p[0] = alu_flgs[0];
      case (flg_op)
        3'd1: p[0] = 1'b0;
        3'd2: p[0] = 1'b1;
        3'd3: p[2] = 1'b0;
        3'd4: p[2] = 1'b1;
        3'd5: p[6] = 1'b0;
        3'd6: p[3] = 1'b0;
        3'd7: p[3] = 1'b1;
        default: ;
      endcase
      if (irq_set_i) p[2] = 1'b1;
      if (plp) begin
        p[7:6] = p_in[7:6];
        p[3:0] = p_in[3:0];
      end
      if (!HAS_D) p[3] = 1'b0;
      if (irq_set_i) begin
        m_ipoll = 1'b1;
        m_irq   = 1'b0;
      end else if (instr_end) begin
        m_irq   = irq_line & ~m_ipoll;
        m_ipoll = p[2];
      end
      m_p = p;
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [7:0] exp_p;
    logic       flag;
    if (chk_en) begin
      exp_p = {m_p[7:6], 1'b1, push_b, m_p[3:0]};
      case (br_sel)
        2'd0: flag = m_p[7];
        2'd1: flag = m_p[6];
        2'd2: flag = m_p[0];
        default: flag = m_p[1];
      endcase
      chk("model_p_out", p_out, exp_p);
      chk("model_irq_req", {7'd0, irq_req}, {7'd0, m_irq});
      chk("model_br_taken", {7'd0, br_taken}, {7'd0, flag == br_val});
    end
  end

  // driver tasks
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; alu_flgs = 4'h0; alu_we = 4'h0; nz_we = 1'b0; nz_data = 8'h00;
    flg_op = 3'd0; plp = 1'b0; p_in = 8'h00; push_b = 1'b1;
    irq_set_i = 1'b0; instr_end = 1'b0; br_sel = 2'd0; br_val = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    irq_line = 1'b0;
    idle();
    chk_en = 1'b1;
    repeat (3) go();
    n_rst = 1'b1;
    @(negedge clk);
    chk("reset_p_out", p_out, 8'h34);
    chk("reset_irq_req", {7'd0, irq_req}, 8'h00);

    // ALU enables beat the load N/Z path where both target a flag
    go();
    alu_flgs = 4'b1011; alu_we = 4'b0101; nz_we = 1'b1; nz_data = 8'h80;
    go();
    idle(); push_b = 1'b0;
    @(negedge clk);
    chk("alu_vs_nz", p_out, 8'hA5);

    // PLP overrides a simultaneous CLC
    go();
    plp = 1'b1; p_in = 8'hFF; flg_op = 3'd1;
    go();
    idle(); push_b = 1'b0;
    @(negedge clk);
    chk("plp_vs_clc", p_out, HAS_D ? 8'hEF : 8'hE7);

    // CLI lowers the mask only from the next poll onward
    go();
    irq_line = 1'b1; instr_end = 1'b1;
    go();
    idle();
    go();
    flg_op = 3'd3; instr_end = 1'b1;
    go();
    idle();
    @(negedge clk);
    chk("cli_late_irq0", {7'd0, irq_req}, 8'h00);
    chk("cli_i_clear", {7'd0, p_out[2]}, 8'h00);
    go();
    instr_end = 1'b1;
    go();
    idle();
    @(negedge clk);
    chk("cli_late_irq1", {7'd0, irq_req}, 8'h01);

    // interrupt entry beats a same-cycle poll
    go();
    irq_set_i = 1'b1; instr_end = 1'b1;
    go();
    idle();
    @(negedge clk);
    chk("irqset_req0", {7'd0, irq_req}, 8'h00);
    chk("irqset_i1", {7'd0, p_out[2]}, 8'h01);
    go();
    instr_end = 1'b1;
    go();
    idle();
    @(negedge clk);
    chk("irqset_no_reentry", {7'd0, irq_req}, 8'h00);

    // build irq_req=1, Z=1, then stall with every strobe active
    go();
    flg_op = 3'd3; instr_end = 1'b1; nz_we = 1'b1; nz_data = 8'h00;
    go();
    idle(); instr_end = 1'b1;
    go();
    idle();
    go();
    en = 1'b0; alu_flgs = 4'h0; alu_we = 4'hF; nz_we = 1'b1; nz_data = 8'h55;
    flg_op = 3'd4; plp = 1'b1; p_in = 8'h00; irq_set_i = 1'b1; instr_end = 1'b1;
    go();
    go();
    idle(); push_b = 1'b0; br_sel = 2'd3; br_val = 1'b1;
    @(negedge clk);
    chk("stall_p_out", p_out, HAS_D ? 8'h6B : 8'h63);
    chk("stall_irq_req", {7'd0, irq_req}, 8'h01);
    chk("br_z_taken", {7'd0, br_taken}, 8'h01);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      go();
      n_rst     = ($urandom_range(0, 499) != 0);
      en        = ($urandom_range(0, 7) != 0);
      alu_flgs  = 4'($urandom);
      alu_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      nz_we     = ($urandom_range(0, 2) == 0);
      nz_data   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      flg_op    = ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'd0;
      plp       = ($urandom_range(0, 7) == 0);
      p_in      = 8'($urandom);
      push_b    = 1'($urandom);
      irq_set_i = ($urandom_range(0, 15) == 0);
      instr_end = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) irq_line = ~irq_line;
      br_sel    = 2'($urandom);
      br_val    = 1'($urandom);
    end
    go();
    n_rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
